// File: rtl/fetch_unit.sv
// Instruction fetch unit: fetches aligned doublewords into an instruction queue, with backend redirect/flush.
// Optional performance counters are enabled by defining FETCH_PERF_CNT_EN.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h1ECEB000,
  parameter int          IQ_DEPTH = 8
) (
  input  logic        clk,
  input  logic        rst,
  output logic [31:0] imem_addr,
  output logic [3:0]  imem_rmask,
  input  logic [63:0] imem_rdata,
  input  logic        imem_resp,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [31:0] instr,
  output logic [31:0] instr_pc
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0] fetch_resp_cnt,
  output logic [31:0] fetch_flush_cnt
`endif
);

  localparam int AW = $clog2(IQ_DEPTH);
  localparam int CW = AW + 1;
  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] REQ     = 2'd1;
  localparam logic [1:0] DISCARD = 2'd2;
  localparam logic [CW-1:0] LIMIT = CW'(IQ_DEPTH - 2);
  localparam logic [31:0] RESET_LINE = RESET_PC & 32'hFFFF_FFF8;

  logic [1:0]    state, state_nxt;
  logic [31:0]   pc, pc_nxt, pc_line;
  logic [31:0]   q_instr [IQ_DEPTH];
  logic [31:0]   q_pc    [IQ_DEPTH];
  logic [AW-1:0] head, tail, tail_p1;
  logic [CW-1:0] count, count_nxt;
  logic          pop, accept;
  logic [1:0]    push_n;

  assign pc_line     = {pc[31:3], 3'b000};
  assign tail_p1     = tail + AW'(1);
  assign imem_rmask  = (state == REQ || state == DISCARD) ? 4'hF : 4'h0;
  assign instr_valid = (count != {CW{1'b0}});
  assign instr       = q_instr[head];
  assign instr_pc    = q_pc[head];
  assign pop         = instr_valid && instr_ready;
  assign accept      = (state == REQ) && imem_resp && !redirect_valid;

  always_comb begin
    push_n = 2'd0;
    if (accept) begin
      push_n = pc[2] ? 2'd1 : 2'd2;
    end else begin
      push_n = 2'd0;
    end
    count_nxt = count + CW'(push_n) - CW'(pop);
  end

  // A new request is only issued when two slots remain free after this cycle's push/pop.
  always_comb begin
    state_nxt = state;
    pc_nxt    = pc;
    if (redirect_valid) begin
      pc_nxt = redirect_pc & 32'hFFFF_FFFC;
      case (state)
        REQ:     state_nxt = imem_resp ? IDLE : DISCARD;
        DISCARD: state_nxt = imem_resp ? IDLE : DISCARD;
        default: state_nxt = IDLE;
      endcase
    end else begin
      case (state)
        IDLE: state_nxt = (count_nxt <= LIMIT) ? REQ : IDLE;
        REQ: begin
          if (imem_resp) begin
            pc_nxt    = pc_line + 32'd8;
            state_nxt = (count_nxt <= LIMIT) ? REQ : IDLE;
          end else begin
            state_nxt = REQ;
          end
        end
        DISCARD: state_nxt = imem_resp ? IDLE : DISCARD;
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      pc        <= RESET_PC;
      imem_addr <= RESET_LINE;
      head      <= {AW{1'b0}};
      tail      <= {AW{1'b0}};
      count     <= {CW{1'b0}};
    end else begin
      state <= state_nxt;
      pc    <= pc_nxt;
      // The stale request keeps its address on the bus until its response drains.
      if (state_nxt != DISCARD) begin
        imem_addr <= pc_nxt & 32'hFFFF_FFF8;
      end
      if (redirect_valid) begin
        head  <= {AW{1'b0}};
        tail  <= {AW{1'b0}};
        count <= {CW{1'b0}};
      end else begin
        head  <= head + AW'(pop);
        tail  <= tail + AW'(push_n);
        count <= count_nxt;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      if (pc[2]) begin
        q_instr[tail] <= imem_rdata[63:32];
        q_pc[tail]    <= pc;
      end else begin
        q_instr[tail]    <= imem_rdata[31:0];
        q_pc[tail]       <= pc;
        q_instr[tail_p1] <= imem_rdata[63:32];
        q_pc[tail_p1]    <= pc + 32'd4;
      end
    end
  end

`ifdef FETCH_PERF_CNT_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fetch_resp_cnt  <= 32'd0;
      fetch_flush_cnt <= 32'd0;
    end else begin
      if (accept) begin
        fetch_resp_cnt <= fetch_resp_cnt + 32'd1;
      end
      if (redirect_valid) begin
        fetch_flush_cnt <= fetch_flush_cnt + 32'd1;
      end
    end
  end
`endif

endmodule
